// File: rtl/lcd_dht_frame_ctrl.sv
// HD44780 character-LCD controller: power-on init, then a two-line humidity/temperature
// frame redrawn for every new DHT11 sample, with one-entry newest-wins sample buffering.
module lcd_dht_frame_ctrl #(
    parameter int TICK_DIV   = 4096,
    parameter int PWR_WAIT   = 16,
    parameter int CLEAR_WAIT = 4,
    parameter int DIGITS     = 3,
    parameter int LZ_BLANK   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   hum_bcd,
    input  logic [4*DIGITS-1:0]   temp_bcd,
    input  logic                  sample_valid,
    input  logic                  sensor_err,
    output logic                  rs,
    output logic                  rw,
    output logic                  en,
    output logic [7:0]            dat,
    output logic                  busy
);

    localparam int CNT_W     = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
    localparam int WAIT_MAX  = (PWR_WAIT > CLEAR_WAIT) ? PWR_WAIT : CLEAR_WAIT;
    localparam int WAIT_W    = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
    localparam int FRAME_LEN = 14 + 2 * DIGITS;
    localparam logic [31:0] HUM_LBL  = "Hum:";
    localparam logic [39:0] TEMP_LBL = "Temp:";

    typedef enum logic [2:0] {PWR, INIT, IDLE, FRAME, CLRWAIT} state_t;
    typedef enum logic [1:0] {SETUP, STROBE, HOLD} phase_t;

    state_t                state_q, state_d;
    phase_t                phase_q, phase_d;
    logic [4:0]            idx_q, idx_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [CNT_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic                  rs_q, rs_d;
    logic                  en_q, en_d;
    logic [7:0]            dat_q, dat_d;
    logic                  busy_q, busy_d;
    logic                  pend_q, pend_d;
    logic [4*DIGITS-1:0]   buf_hum_q, buf_hum_d, buf_temp_q, buf_temp_d;
    logic                  buf_err_q, buf_err_d;
    logic [4*DIGITS-1:0]   frm_hum_q, frm_hum_d, frm_temp_q, frm_temp_d;
    logic                  frm_err_q, frm_err_d;

    logic                  tick;
    logic [4:0]            idx_next;
    logic                  have_sample;
    logic [4*DIGITS-1:0]   new_hum, new_temp;
    logic                  new_err;
    logic                  last_byte;
    logic                  start_frame;
    logic [8*DIGITS-1:0]   hum_chars, temp_chars;
    logic [7:0]            frm_byte;
    logic                  frm_rs;

    function automatic logic [7:0] init_byte(input logic [4:0] i);
        case (i)
            5'd0, 5'd1: return 8'h38;
            5'd2:       return 8'h0C;
            5'd3:       return 8'h06;
            default:    return 8'h01;
        endcase
    endfunction

    // Characters for one value, MSD in the top byte; leading-zero state runs left to right.
    function automatic logic [8*DIGITS-1:0] digit_chars(input logic [4*DIGITS-1:0] val,
                                                         input logic err);
        logic                lead;
        logic [3:0]          nib;
        logic [7:0]          c;
        logic [8*DIGITS-1:0] chars;
        lead  = 1'b1;
        chars = '0;
        for (int k = 0; k < DIGITS; k++) begin
            nib = val[4*(DIGITS-1-k) +: 4];
            if (nib != 4'd0) lead = 1'b0;
            if (err)
                c = 8'h2D;
            else if ((LZ_BLANK != 0) && lead && (k != DIGITS - 1))
                c = 8'h20;
            else if (nib > 4'd9)
                c = 8'h3F;
            else
                c = {4'h3, nib};
            chars[8*(DIGITS-1-k) +: 8] = c;
        end
        return chars;
    endfunction

    assign hum_chars  = digit_chars(frm_hum_q, frm_err_q);
    assign temp_chars = digit_chars(frm_temp_q, frm_err_q);
    assign tick       = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
    assign idx_next   = idx_q + 5'd1;

    always_comb begin
        int i;
        int j;
        i        = int'(idx_next);
        j        = 0;
        frm_byte = 8'h43;
        frm_rs   = 1'b1;
        if (i == 0) begin
            frm_byte = 8'h80;
            frm_rs   = 1'b0;
        end else if (i <= 4) begin
            frm_byte = HUM_LBL[8*(4-i) +: 8];
        end else if (i < 5 + DIGITS) begin
            j        = i - 5;
            frm_byte = hum_chars[8*(DIGITS-1-j) +: 8];
        end else if (i == 5 + DIGITS) begin
            frm_byte = 8'h25;
        end else if (i == 6 + DIGITS) begin
            frm_byte = 8'hC0;
            frm_rs   = 1'b0;
        end else if (i < 12 + DIGITS) begin
            j        = i - (7 + DIGITS);
            frm_byte = TEMP_LBL[8*(4-j) +: 8];
        end else if (i < 12 + 2 * DIGITS) begin
            j        = i - (12 + DIGITS);
            frm_byte = temp_chars[8*(DIGITS-1-j) +: 8];
        end else if (i == 12 + 2 * DIGITS) begin
            frm_byte = 8'hDF;
        end
    end

    // A strobe in the same cycle counts as pending so a frame can chain without a gap.
    assign have_sample = pend_q | sample_valid;
    assign new_hum     = sample_valid ? hum_bcd    : buf_hum_q;
    assign new_temp    = sample_valid ? temp_bcd   : buf_temp_q;
    assign new_err     = sample_valid ? sensor_err : buf_err_q;
    assign last_byte   = (state_q == INIT) ? (idx_q == 5'd4) : (idx_q == 5'(FRAME_LEN - 1));

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        rs_d        = rs_q;
        en_d        = en_q;
        dat_d       = dat_q;
        busy_d      = busy_q;
        pend_d      = pend_q;
        buf_hum_d   = buf_hum_q;
        buf_temp_d  = buf_temp_q;
        buf_err_d   = buf_err_q;
        frm_hum_d   = frm_hum_q;
        frm_temp_d  = frm_temp_q;
        frm_err_d   = frm_err_q;
        start_frame = 1'b0;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + CNT_W'(1);

        if (sample_valid) begin
            pend_d     = 1'b1;
            buf_hum_d  = hum_bcd;
            buf_temp_d = temp_bcd;
            buf_err_d  = sensor_err;
        end

        if (tick) begin
            case (state_q)
                PWR: begin
                    if (wait_q == WAIT_W'(PWR_WAIT - 1)) begin
                        state_d = INIT;
                        idx_d   = 5'd0;
                        phase_d = SETUP;
                        rs_d    = 1'b0;
                        en_d    = 1'b0;
                        dat_d   = init_byte(5'd0);
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                INIT, FRAME: begin
                    case (phase_q)
                        SETUP: begin
                            en_d    = 1'b1;
                            phase_d = STROBE;
                        end
                        STROBE: begin
                            en_d    = 1'b0;
                            phase_d = HOLD;
                        end
                        default: begin
                            if (!last_byte) begin
                                idx_d   = idx_next;
                                phase_d = SETUP;
                                if (state_q == INIT) begin
                                    rs_d  = 1'b0;
                                    dat_d = init_byte(idx_next);
                                end else begin
                                    rs_d  = frm_rs;
                                    dat_d = frm_byte;
                                end
                            end else if (state_q == INIT) begin
                                state_d = CLRWAIT;
                                wait_d  = '0;
                            end else if (have_sample) begin
                                start_frame = 1'b1;
                            end else begin
                                state_d = IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                    endcase
                end
                CLRWAIT: begin
                    if (wait_q == WAIT_W'(CLEAR_WAIT - 1)) begin
                        if (have_sample) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                default: begin
                    if (have_sample) start_frame = 1'b1;
                end
            endcase
        end

        // Frame registers only change here, so a running frame never sees a newer sample.
        if (start_frame) begin
            state_d    = FRAME;
            busy_d     = 1'b1;
            idx_d      = 5'd0;
            phase_d    = SETUP;
            rs_d       = 1'b0;
            en_d       = 1'b0;
            dat_d      = 8'h80;
            pend_d     = 1'b0;
            frm_hum_d  = new_hum;
            frm_temp_d = new_temp;
            frm_err_d  = new_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PWR;
            phase_q    <= SETUP;
            idx_q      <= '0;
            wait_q     <= '0;
            tick_cnt_q <= '0;
            rs_q       <= 1'b0;
            en_q       <= 1'b0;
            dat_q      <= 8'h00;
            busy_q     <= 1'b1;
            pend_q     <= 1'b0;
            buf_hum_q  <= '0;
            buf_temp_q <= '0;
            buf_err_q  <= 1'b0;
            frm_hum_q  <= '0;
            frm_temp_q <= '0;
            frm_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            wait_q     <= wait_d;
            tick_cnt_q <= tick_cnt_d;
            rs_q       <= rs_d;
            en_q       <= en_d;
            dat_q      <= dat_d;
            busy_q     <= busy_d;
            pend_q     <= pend_d;
            buf_hum_q  <= buf_hum_d;
            buf_temp_q <= buf_temp_d;
            buf_err_q  <= buf_err_d;
            frm_hum_q  <= frm_hum_d;
            frm_temp_q <= frm_temp_d;
            frm_err_q  <= frm_err_d;
        end
    end

    assign rs   = rs_q;
    assign rw   = 1'b0;
    assign en   = en_q;
    assign dat  = dat_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_lcd_dht_frame_ctrl.sv
// Bench for lcd_dht_frame_ctrl: two instances (blanking on/off) share stimulus; every byte
// strobed onto the bus is matched against a queue of expected bytes filled when samples are sent.
module tb_lcd_dht_frame_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int PWR_WAIT    = 16;
    localparam int CLEAR_WAIT  = 4;
    localparam int DIGITS      = 3;
    localparam int FRAME_TICKS = 3 * (14 + 2 * DIGITS);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [4*DIGITS-1:0] hum_bcd = '0;
    logic [4*DIGITS-1:0] temp_bcd = '0;
    logic                sample_valid = 1'b0;
    logic                sensor_err = 1'b0;
    logic                rs, rw, en, busy;
    logic [7:0]          dat;
    logic                rs_nb, rw_nb, en_nb, busy_nb;
    logic [7:0]          dat_nb;

    int vectors = 0;
    int miscompares = 0;
    int bytes_seen = 0;
    logic [8:0] exp_q1[$];
    logic [8:0] exp_q0[$];
    logic en1_prev = 1'b0;
    logic en0_prev = 1'b0;

    always #5 clk = ~clk;

    lcd_dht_frame_ctrl #(
        .TICK_DIV(TICK_DIV), .PWR_WAIT(PWR_WAIT), .CLEAR_WAIT(CLEAR_WAIT),
        .DIGITS(DIGITS), .LZ_BLANK(1)
    ) dut (
        .clk(clk), .rst(rst), .hum_bcd(hum_bcd), .temp_bcd(temp_bcd),
        .sample_valid(sample_valid), .sensor_err(sensor_err),
        .rs(rs), .rw(rw), .en(en), .dat(dat), .busy(busy)
    );

    lcd_dht_frame_ctrl #(
        .TICK_DIV(TICK_DIV), .PWR_WAIT(PWR_WAIT), .CLEAR_WAIT(CLEAR_WAIT),
        .DIGITS(DIGITS), .LZ_BLANK(0)
    ) dut_nb (
        .clk(clk), .rst(rst), .hum_bcd(hum_bcd), .temp_bcd(temp_bcd),
        .sample_valid(sample_valid), .sensor_err(sensor_err),
        .rs(rs_nb), .rw(rw_nb), .en(en_nb), .dat(dat_nb), .busy(busy_nb)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] exp_digit(input logic [4*DIGITS-1:0] val, input int k,
                                             input logic err, input int lz);
        logic [4*DIGITS-1:0] upper;
        logic [3:0]          nib;
        upper = val >> (4 * (DIGITS - 1 - k));
        nib   = upper[3:0];
        if (err) return 8'h2D;
        if (lz != 0 && k < DIGITS - 1 && upper == '0) return 8'h20;
        if (nib > 4'd9) return 8'h3F;
        return 8'h30 + {4'h0, nib};
    endfunction

    task automatic q_push(input int lz, input logic rsv, input logic [7:0] b);
        if (lz != 0) exp_q1.push_back({rsv, b});
        else exp_q0.push_back({rsv, b});
    endtask

    task automatic push_init();
        for (int lz = 0; lz < 2; lz++) begin
            q_push(lz, 1'b0, 8'h38);
            q_push(lz, 1'b0, 8'h38);
            q_push(lz, 1'b0, 8'h0C);
            q_push(lz, 1'b0, 8'h06);
            q_push(lz, 1'b0, 8'h01);
        end
    endtask

    task automatic push_frame(input logic [4*DIGITS-1:0] h, input logic [4*DIGITS-1:0] t,
                              input logic e);
        for (int lz = 0; lz < 2; lz++) begin
            q_push(lz, 1'b0, 8'h80);
            q_push(lz, 1'b1, 8'h48);
            q_push(lz, 1'b1, 8'h75);
            q_push(lz, 1'b1, 8'h6D);
            q_push(lz, 1'b1, 8'h3A);
            for (int k = 0; k < DIGITS; k++) q_push(lz, 1'b1, exp_digit(h, k, e, lz));
            q_push(lz, 1'b1, 8'h25);
            q_push(lz, 1'b0, 8'hC0);
            q_push(lz, 1'b1, 8'h54);
            q_push(lz, 1'b1, 8'h65);
            q_push(lz, 1'b1, 8'h6D);
            q_push(lz, 1'b1, 8'h70);
            q_push(lz, 1'b1, 8'h3A);
            for (int k = 0; k < DIGITS; k++) q_push(lz, 1'b1, exp_digit(t, k, e, lz));
            q_push(lz, 1'b1, 8'hDF);
            q_push(lz, 1'b1, 8'h43);
        end
    endtask

    task automatic applyStimulus(input logic [4*DIGITS-1:0] h, input logic [4*DIGITS-1:0] t,
                                 input logic e, input logic push);
        @(negedge clk);
        hum_bcd      = h;
        temp_bcd     = t;
        sensor_err   = e;
        sample_valid = 1'b1;
        if (push) push_frame(h, t, e);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_busy(output int lat, output int high);
        lat  = 0;
        high = 0;
        while (!busy && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        while (busy && high < 2000) begin
            @(posedge clk);
            #1;
            high++;
        end
    endtask

    task automatic check_init(input string tag);
        int n;
        int rise_at;
        int fall_at;
        rise_at = -1;
        fall_at = -1;
        @(negedge clk);
        rst = 1'b0;
        for (n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (rise_at < 0 && en) rise_at = n;
            if (!busy) begin
                fall_at = n;
                break;
            end
        end
        checkOutput({tag, "_first_en_cycle"}, rise_at, TICK_DIV * (PWR_WAIT + 1));
        checkOutput({tag, "_busy_fall_cycle"}, fall_at, TICK_DIV * (PWR_WAIT + 15 + CLEAR_WAIT));
    endtask

    // Byte capture on each falling edge of en, sampled mid-cycle.
    always @(negedge clk) begin
        logic [8:0] e1;
        logic [8:0] e0;
        if (rst) begin
            en1_prev = 1'b0;
            en0_prev = 1'b0;
        end else begin
            if (en1_prev && !en) begin
                bytes_seen++;
                checkOutput("lz1_byte_expected", 32'(exp_q1.size() != 0), 32'd1);
                if (exp_q1.size() != 0) begin
                    e1 = exp_q1.pop_front();
                    checkOutput("lz1_byte", {rw, rs, dat}, {1'b0, e1});
                end
            end
            if (en0_prev && !en_nb) begin
                checkOutput("lz0_byte_expected", 32'(exp_q0.size() != 0), 32'd1);
                if (exp_q0.size() != 0) begin
                    e0 = exp_q0.pop_front();
                    checkOutput("lz0_byte", {rw_nb, rs_nb, dat_nb}, {1'b0, e0});
                end
            end
            en1_prev = en;
            en0_prev = en_nb;
        end
    end

    initial begin
        int lat;
        int high;
        int base;
        int n;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rs", rs, 0);
        checkOutput("reset_rw", rw, 0);
        checkOutput("reset_en", en, 0);
        checkOutput("reset_dat", dat, 0);
        checkOutput("reset_busy", busy, 1);

        push_init();
        check_init("init");

        applyStimulus(12'h045, 12'h023, 1'b0, 1'b1);
        wait_busy(lat, high);
        checkOutput("frame_latency_ok", 32'(lat <= TICK_DIV), 32'd1);
        checkOutput("frame_busy_cycles", high, FRAME_TICKS * TICK_DIV);

        applyStimulus(12'h000, 12'h1A0, 1'b0, 1'b1);
        wait_busy(lat, high);
        checkOutput("blank_busy_cycles", high, FRAME_TICKS * TICK_DIV);

        applyStimulus(12'h123, 12'h456, 1'b1, 1'b1);
        wait_busy(lat, high);
        checkOutput("err_busy_cycles", high, FRAME_TICKS * TICK_DIV);

        // Three strobes during one frame: only the newest produces a follow-on frame.
        applyStimulus(12'h111, 12'h222, 1'b0, 1'b1);
        fork
            wait_busy(lat, high);
            begin
                repeat (20) @(posedge clk);
                applyStimulus(12'h333, 12'h444, 1'b0, 1'b0);
                repeat (10) @(posedge clk);
                applyStimulus(12'h555, 12'h666, 1'b1, 1'b0);
                repeat (10) @(posedge clk);
                applyStimulus(12'h987, 12'h654, 1'b0, 1'b1);
            end
        join
        checkOutput("buffer_busy_cycles", high, 2 * FRAME_TICKS * TICK_DIV);

        // Strobe landing exactly on the frame's final tick edge.
        applyStimulus(12'h099, 12'h100, 1'b0, 1'b1);
        fork
            wait_busy(lat, high);
            begin
                for (n = 0; n < 100 && !busy; n++) begin
                    @(posedge clk);
                    #1;
                end
                repeat (FRAME_TICKS * TICK_DIV - 1) @(posedge clk);
                applyStimulus(12'h007, 12'h010, 1'b0, 1'b1);
            end
        join
        checkOutput("edge_busy_cycles", high, 2 * FRAME_TICKS * TICK_DIV);

        // Reset in the middle of a frame.
        base = bytes_seen;
        applyStimulus(12'h045, 12'h023, 1'b0, 1'b1);
        for (n = 0; n < 1000 && bytes_seen < base + 7; n++) @(posedge clk);
        checkOutput("midreset_point_reached", 32'(bytes_seen >= base + 7), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midreset_en", en, 0);
        checkOutput("midreset_dat", dat, 0);
        checkOutput("midreset_busy", busy, 1);
        checkOutput("midreset_rs", rs, 0);
        exp_q1.delete();
        exp_q0.delete();
        push_init();
        repeat (2) @(posedge clk);
        check_init("reinit");

        applyStimulus(12'h250, 12'h038, 1'b0, 1'b1);
        wait_busy(lat, high);
        checkOutput("post_reset_busy_cycles", high, FRAME_TICKS * TICK_DIV);

        repeat (20) @(posedge clk);
        checkOutput("lz1_queue_drained", exp_q1.size(), 0);
        checkOutput("lz0_queue_drained", exp_q0.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
